// File: rtl/pico_mem_responder.sv
// rtl/pico_mem_responder.sv - PicoRV32 memory responder on a 128-bit SRAM shared with an external master
// Optional one-line core read buffer: define PICO_MEM_LINEBUF_EN.
module pico_mem_responder #(
    parameter int PICO_MEM_DATA_SIZE = 32,
    parameter int PICO_MEM_ADDR_SIZE = 32,
    parameter int ASM_MEM_DATA_SIZE  = 128,
    parameter int SRAM_ADDR_SIZE     = 12,
    parameter int MAX_EXT_WIN        = 4
) (
    input  logic                          clk_i,
    input  logic                          resetn_i,
    input  logic                          mem_en_i,
    input  logic [3:0]                    mem_we_i,
    input  logic [PICO_MEM_ADDR_SIZE-1:0] mem_addr_i,
    input  logic [PICO_MEM_DATA_SIZE-1:0] mem_wdata_i,
    output logic [PICO_MEM_DATA_SIZE-1:0] mem_rdata_o,
    output logic                          mem_stall_o,
    output logic                          mem_err_o,
    input  logic                          ext_req_i,
    input  logic [15:0]                   ext_we_i,
    input  logic [PICO_MEM_ADDR_SIZE-1:0] ext_addr_i,
    input  logic [ASM_MEM_DATA_SIZE-1:0]  ext_wdata_i,
    output logic                          ext_gnt_o,
    output logic [ASM_MEM_DATA_SIZE-1:0]  ext_rdata_o,
    output logic                          sram_en_o,
    output logic [15:0]                   sram_we_o,
    output logic [SRAM_ADDR_SIZE-1:0]     sram_addr_o,
    output logic [ASM_MEM_DATA_SIZE-1:0]  sram_wdata_o,
    input  logic [ASM_MEM_DATA_SIZE-1:0]  sram_rdata_i
);

    localparam int LW = SRAM_ADDR_SIZE;
    localparam int CW = $clog2(MAX_EXT_WIN + 1);
    localparam logic [CW-1:0] WIN_MAX = CW'(MAX_EXT_WIN);

    logic [LW-1:0]  core_line;
    logic [LW-1:0]  ext_line;
    logic [1:0]     core_word;
    logic           core_oor;
    logic           core_rd;
    logic           ext_wr;
    logic           buf_hit;
    logic [31:0]    hit_word;
    logic           core_acc;
    logic           core_sram;

    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           rd_pend_q, rd_pend_d;
    logic [1:0]     rd_word_q, rd_word_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           ext_pend_q, ext_pend_d;
    logic [127:0]   ext_rdata_q, ext_rdata_d;

    logic           unused_bits;
    assign unused_bits = ^{mem_addr_i[1:0], ext_addr_i[3:0],
                           ext_addr_i[PICO_MEM_ADDR_SIZE-1:LW+4]};

    // Address decode and external grant; the external port only loses once the core has waited its window
    always_comb begin
        core_line = mem_addr_i[LW+3:4];
        core_word = mem_addr_i[3:2];
        core_oor  = |mem_addr_i[PICO_MEM_ADDR_SIZE-1:LW+4];
        core_rd   = mem_en_i && (mem_we_i == 4'h0);
        ext_line  = ext_addr_i[LW+3:4];
        ext_gnt_o = ext_req_i && (wait_cnt_q < WIN_MAX);
        ext_wr    = ext_gnt_o && (ext_we_i != 16'h0);
    end

`ifdef PICO_MEM_LINEBUF_EN
    logic [127:0]  buf_q, buf_d;
    logic [LW-1:0] buf_tag_q, buf_tag_d;
    logic          buf_valid_q, buf_valid_d;
    logic [LW-1:0] rd_line_q, rd_line_d;
    logic          sram_wr;

    // Hit lookup; an external write to the buffered line this cycle turns the hit into a miss
    always_comb begin
        buf_hit  = core_rd && !core_oor && buf_valid_q && (buf_tag_q == core_line)
                   && !(ext_wr && (ext_line == buf_tag_q));
        hit_word = buf_q[{core_word, 5'b0} +: 32];
    end

    // Fill on miss return, invalidate on any write landing on the buffered (or arriving) line
    always_comb begin
        sram_wr     = sram_en_o && (sram_we_o != 16'h0);
        buf_d       = buf_q;
        buf_tag_d   = buf_tag_q;
        buf_valid_d = buf_valid_q && !(sram_wr && (sram_addr_o == buf_tag_q));
        rd_line_d   = core_sram ? core_line : rd_line_q;
        if (rd_pend_q) begin
            buf_d       = sram_rdata_i;
            buf_tag_d   = rd_line_q;
            buf_valid_d = !(sram_wr && (sram_addr_o == rd_line_q));
        end
    end

    // Line buffer state
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            buf_q       <= '0;
            buf_tag_q   <= '0;
            buf_valid_q <= 1'b0;
            rd_line_q   <= '0;
        end else begin
            buf_q       <= buf_d;
            buf_tag_q   <= buf_tag_d;
            buf_valid_q <= buf_valid_d;
            rd_line_q   <= rd_line_d;
        end
    end
`else
    // Without a buffer every core read goes to the SRAM
    always_comb begin
        buf_hit  = 1'b0;
        hit_word = '0;
    end
`endif

    // Arbitration and SRAM port mux: external grant owns the SRAM, otherwise an accepted in-range core miss/write
    always_comb begin
        mem_stall_o  = mem_en_i && ext_gnt_o && !buf_hit;
        core_acc     = mem_en_i && !mem_stall_o;
        core_sram    = core_acc && !core_oor && !buf_hit;
        sram_en_o    = 1'b0;
        sram_we_o    = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (ext_gnt_o) begin
            sram_en_o    = 1'b1;
            sram_we_o    = ext_we_i;
            sram_addr_o  = ext_line;
            sram_wdata_o = ext_wdata_i;
        end else if (core_sram) begin
            sram_en_o    = 1'b1;
            sram_we_o    = 16'(mem_we_i) << {core_word, 2'b00};
            sram_addr_o  = core_line;
            sram_wdata_o = {4{mem_wdata_i}};
        end
    end

    // Core read return: SRAM misses forward combinationally at T+1, hits and out-of-range reads are registered at T
    always_comb begin
        mem_rdata_o = rd_pend_q ? sram_rdata_i[{rd_word_q, 5'b0} +: 32] : rdata_q;
        mem_err_o   = err_q;
        rdata_d     = mem_rdata_o;
        if (core_acc && core_rd) begin
            if (core_oor) begin
                rdata_d = '0;
            end else if (buf_hit) begin
                rdata_d = hit_word;
            end
        end
        rd_pend_d = core_sram && core_rd;
        rd_word_d = core_sram ? core_word : rd_word_q;
        err_d     = core_acc && core_oor;
    end

    // External read return and held data
    always_comb begin
        ext_rdata_o = ext_pend_q ? sram_rdata_i : ext_rdata_q;
        ext_rdata_d = ext_rdata_o;
        ext_pend_d  = ext_gnt_o && !ext_wr;
    end

    // Anti-starvation counter: counts stalled cycles of a held core request
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!mem_en_i || core_acc) begin
            wait_cnt_d = '0;
        end else if (mem_stall_o && (wait_cnt_q != WIN_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Response and arbitration state
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wait_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_word_q   <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ext_pend_q  <= 1'b0;
            ext_rdata_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_word_q   <= rd_word_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            ext_pend_q  <= ext_pend_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

endmodule

// File: tb/tb_pico_mem_responder.sv
// tb/tb_pico_mem_responder.sv - scoreboard bench for pico_mem_responder
module tb_pico_mem_responder;

    logic         clk_i = 1'b0;
    logic         resetn_i;
    logic         mem_en_i;
    logic [3:0]   mem_we_i;
    logic [31:0]  mem_addr_i;
    logic [31:0]  mem_wdata_i;
    logic [31:0]  mem_rdata_o;
    logic         mem_stall_o;
    logic         mem_err_o;
    logic         ext_req_i;
    logic [15:0]  ext_we_i;
    logic [31:0]  ext_addr_i;
    logic [127:0] ext_wdata_i;
    logic         ext_gnt_o;
    logic [127:0] ext_rdata_o;
    logic         sram_en_o;
    logic [15:0]  sram_we_o;
    logic [11:0]  sram_addr_o;
    logic [127:0] sram_wdata_o;
    logic [127:0] sram_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    pico_mem_responder dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .mem_en_i(mem_en_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
        .mem_stall_o(mem_stall_o), .mem_err_o(mem_err_o),
        .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
        .ext_wdata_i(ext_wdata_i), .ext_gnt_o(ext_gnt_o), .ext_rdata_o(ext_rdata_o),
        .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
    );

    typedef struct { int due; logic [31:0] val; bit err; bit rd; } core_exp_t;
    typedef struct { int due; logic [127:0] val; } ext_exp_t;

    core_exp_t    cq[$];
    ext_exp_t     eq[$];
    core_exp_t    ci;
    ext_exp_t     ei;
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    int           wcnt_m = 0;
    logic [31:0]  last_core = '0;
    logic [127:0] last_ext = '0;
    logic [127:0] ref_mem [0:4095];
    logic [127:0] sram_mem [0:4095];
    logic         s_acc, s_gnt, s_stall, s_en;
    logic [15:0]  s_we;
    logic [11:0]  s_addr;
    logic [127:0] s_wdata;

    function automatic logic [127:0] init_val(input int i);
        return {i * 32'h9E3779B1, i * 32'h85EBCA6B, i * 32'hC2B2AE35, i * 32'h27D4EB2F};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency; request captured mid-cycle, applied at the edge
    initial begin
        logic         p_en;
        logic [15:0]  p_we;
        logic [11:0]  p_addr;
        logic [127:0] p_wd;
        logic [127:0] t;
        for (int i = 0; i < 4096; i++) sram_mem[i] = init_val(i);
        forever begin
            @(negedge clk_i);
            p_en = sram_en_o; p_we = sram_we_o; p_addr = sram_addr_o; p_wd = sram_wdata_o;
            @(posedge clk_i);
            if (p_en) begin
                t = sram_mem[p_addr];
                sram_rdata_i <= t;
                for (int b = 0; b < 16; b++) if (p_we[b]) t[b*8 +: 8] = p_wd[b*8 +: 8];
                sram_mem[p_addr] = t;
            end
        end
    end

    // Monitor: compares returned data against the scoreboard each cycle, held value otherwise
    always @(negedge clk_i) begin
        if (resetn_i) begin
            if (cq.size() > 0 && cq[0].due < cyc) begin
                chk("core_resp_missed", 128'(cq[0].due), 128'(cyc));
                void'(cq.pop_front());
            end
            if (cq.size() > 0 && cq[0].due == cyc) begin
                ci = cq.pop_front();
                if (ci.rd) begin
                    chk("core_rdata", mem_rdata_o, ci.val);
                    last_core = ci.val;
                end else begin
                    chk("core_rdata_hold", mem_rdata_o, last_core);
                end
                chk("core_err", mem_err_o, ci.err);
            end else begin
                chk("core_rdata_hold", mem_rdata_o, last_core);
                chk("core_err_idle", mem_err_o, 1'b0);
            end
            if (eq.size() > 0 && eq[0].due == cyc) begin
                ei = eq.pop_front();
                chk("ext_rdata", ext_rdata_o, ei.val);
                last_ext = ei.val;
            end else begin
                chk("ext_rdata_hold", ext_rdata_o, last_ext);
            end
        end
    end

    // One bus cycle: drive, sample, and advance the reference model
    task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic er, input logic [15:0] ewe,
                        input logic [31:0] ea, input logic [127:0] ewd);
        logic [11:0]  cl;
        logic [11:0]  el;
        logic [1:0]   cw;
        logic         oor;
        logic         exp_gnt;
        logic [127:0] v;
        @(posedge clk_i);
        #1;
        mem_en_i = en; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wd;
        ext_req_i = er; ext_we_i = ewe; ext_addr_i = ea; ext_wdata_i = ewd;
        @(negedge clk_i);
        s_gnt = ext_gnt_o; s_stall = mem_stall_o; s_en = sram_en_o;
        s_we = sram_we_o; s_addr = sram_addr_o; s_wdata = sram_wdata_o;
        exp_gnt = er && (wcnt_m < 4);
        chk("ext_gnt", s_gnt, exp_gnt);
`ifndef PICO_MEM_LINEBUF_EN
        chk("mem_stall", s_stall, en && exp_gnt);
`endif
        s_acc = en && !s_stall;
        cl = addr[15:4]; cw = addr[3:2]; oor = |addr[31:16]; el = ea[15:4];
        if (s_acc && we == 4'h0) begin
            v = ref_mem[cl];
            cq.push_back('{due: cyc + 1, val: oor ? 32'h0 : v[cw*32 +: 32], err: oor, rd: 1'b1});
        end else if (s_acc && oor) begin
            cq.push_back('{due: cyc + 1, val: 32'h0, err: 1'b1, rd: 1'b0});
        end
        if (s_gnt) begin
            if (ewe == 16'h0) begin
                eq.push_back('{due: cyc + 1, val: ref_mem[el]});
            end else begin
                v = ref_mem[el];
                for (int b = 0; b < 16; b++) if (ewe[b]) v[b*8 +: 8] = ewd[b*8 +: 8];
                ref_mem[el] = v;
            end
        end
        if (s_acc && we != 4'h0 && !oor) begin
            v = ref_mem[cl];
            for (int b = 0; b < 4; b++) if (we[b]) v[cw*32 + b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[cl] = v;
        end
        if (!en || s_acc) wcnt_m = 0;
        else if (s_stall && wcnt_m < 4) wcnt_m++;
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 16'h0, 32'h0, 128'h0);
    endtask

    initial begin
        logic         r_en;
        logic [3:0]   r_we;
        logic [31:0]  r_addr;
        logic [31:0]  r_wd;
        logic [31:0]  tmp;
        logic [11:0]  ln;
        logic [1:0]   wd2;
        logic [15:0]  hi;
        logic [15:0]  ewe;
        logic [127:0] ewd;
        int           stalls;
        logic         acc_gnt;

        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        resetn_i = 1'b0;
        mem_en_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        ext_req_i = 0; ext_we_i = 0; ext_addr_i = 0; ext_wdata_i = 0;
        repeat (3) @(posedge clk_i);
        #1 resetn_i = 1'b1;
        @(negedge clk_i);
        chk("rst_stall", mem_stall_o, 1'b0);
        chk("rst_gnt", ext_gnt_o, 1'b0);
        chk("rst_sram_en", sram_en_o, 1'b0);
        chk("rst_rdata", mem_rdata_o, 32'h0);
        chk("rst_ext_rdata", ext_rdata_o, 128'h0);
        chk("rst_err", mem_err_o, 1'b0);

        // Core write then read back of 0x24
        step(1'b1, 4'hF, 32'h24, 32'hDEADBEEF, 1'b0, 16'h0, 32'h0, 128'h0);
        chk("wr_sram_en", s_en, 1'b1);
        chk("wr_sram_we", s_we, 16'h00F0);
        chk("wr_sram_addr", s_addr, 12'd2);
        chk("wr_sram_wdata", s_wdata, {4{32'hDEADBEEF}});
        step(1'b1, 4'h0, 32'h24, 32'h0, 1'b0, 16'h0, 32'h0, 128'h0);
        chk("rd_sram_we", s_we, 16'h0);
        idle();
        idle();

        // External port holds the SRAM; the core is forced through after the window
        stalls = 0;
        acc_gnt = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 4'h0, 32'h300, 32'h0, 1'b1, 16'h0, 32'h50, 128'h0);
            if (s_acc) begin
                acc_gnt = s_gnt;
                break;
            end
            stalls++;
        end
        chk("starve_stall_cycles", 128'(stalls), 128'd4);
        chk("starve_gnt_at_accept", acc_gnt, 1'b0);
        idle();

`ifdef PICO_MEM_LINEBUF_EN
        // Buffer hit is served while the external port owns the SRAM
        step(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 16'h0, 32'h0, 128'h0);
        idle();
        step(1'b1, 4'h0, 32'h44, 32'h0, 1'b1, 16'h0, 32'h90, 128'h0);
        chk("hit_stall", s_stall, 1'b0);
        chk("hit_sram_addr_ext", s_addr, 12'd9);
        idle();
        // External write to the buffered line forces a miss with new data
        step(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 16'h0, 32'h0, 128'h0);
        idle();
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 16'hFFFF, 32'h40, {4{32'h11111111}});
        step(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 16'h0, 32'h0, 128'h0);
        chk("inval_miss_sram_en", s_en, 1'b1);
        chk("inval_miss_addr", s_addr, 12'd4);
        idle();
`endif

        // Out-of-range core read
        step(1'b1, 4'h0, 32'h0001_0000, 32'h0, 1'b0, 16'h0, 32'h0, 128'h0);
        chk("oor_sram_en", s_en, 1'b0);
        idle();
        idle();

        // Reset in the cycle after a read miss is accepted
        step(1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 16'h0, 32'h0, 128'h0);
        @(posedge clk_i);
        #1;
        resetn_i = 1'b0;
        mem_en_i = 0; mem_we_i = 0; ext_req_i = 0; ext_we_i = 0;
        cq.delete(); eq.delete();
        last_core = '0; last_ext = '0; wcnt_m = 0;
        #1;
        chk("midrst_rdata", mem_rdata_o, 32'h0);
        chk("midrst_ext_rdata", ext_rdata_o, 128'h0);
        chk("midrst_err", mem_err_o, 1'b0);
        chk("midrst_sram_en", sram_en_o, 1'b0);
        repeat (2) @(posedge clk_i);
        #1 resetn_i = 1'b1;
        repeat (3) idle();

        // Randomized traffic; core requests are held until accepted
        r_en = 1'b0; r_we = 0; r_addr = 0; r_wd = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!r_en || s_acc) begin
                r_en = ($urandom_range(0, 3) != 0);
                r_we = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
                ln = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 7));
                wd2 = 2'($urandom);
                hi = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
                r_addr = {hi, ln, wd2, 2'b00};
                r_wd = $urandom;
            end
            tmp = $urandom;
            ln = 12'($urandom_range(0, 7));
            ewe = ($urandom_range(0, 1) != 0) ? 16'h0 : 16'($urandom);
            ewd = {$urandom, $urandom, $urandom, $urandom};
            step(r_en, r_we, r_addr, r_wd, ($urandom_range(0, 2) == 0), ewe,
                 {tmp[31:16], ln, tmp[3:0]}, ewd);
        end
        repeat (3) idle();
        chk("core_queue_drained", 128'(cq.size()), 128'd0);
        chk("ext_queue_drained", 128'(eq.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
